cdc_strobe_scheduler: RTL

- Source-domain stage directly upstream of the CDC strobe handshake block; drives its source_strobe and consumes its source_stall.
- Accepts single-cycle event requests at any rate and counts them in a saturating pending counter.
- Issues one-cycle strobes into the CDC, one at a time, each only after the previous handshake has fully completed (source_stall rose, then fell).
- Provides status counters and error flags for the source-side controller.

---
 rtl/cdc_strobe_pkg.sv | 8 +
 rtl/cdc_sat_counter.sv | 23 ++
 rtl/cdc_strobe_scheduler.sv | 79 +++++++
 3 files changed

// File: rtl/cdc_strobe_pkg.sv
// cdc_strobe_pkg: shared state encoding and widths for the CDC strobe scheduler
package cdc_strobe_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} sched_state_e;
  localparam int GAP_W = 8;
  function automatic int timer_w(int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/cdc_sat_counter.sv
// cdc_sat_counter: up/down counter that saturates at both ends, with clear and overflow pulse
module cdc_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         ovf_o
);
  localparam logic [W-1:0] MAX = '1;
  logic [W-1:0] count_q;
  assign count_o = count_q;
  assign ovf_o = inc_i & ~dec_i & ~clr_i & (count_q == MAX);
  // clear beats everything; a lone increment at MAX or decrement at zero holds
  always_ff @(posedge clk) begin
    if (rst || clr_i) count_q <= '0;
    else if (inc_i && !dec_i && count_q != MAX) count_q <= count_q + W'(1);
    else if (dec_i && !inc_i && count_q != '0) count_q <= count_q - W'(1);
  end
endmodule

// File: rtl/cdc_strobe_scheduler.sv
// cdc_strobe_scheduler: queues events and issues one strobe per completed CDC handshake (CDC_STROBE_TIMEOUT_EN adds a wait-state abort timer)
module cdc_strobe_scheduler
  import cdc_strobe_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int MIN_GAP        = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             source_clk,
  input  logic             source_reset,
  input  logic             event_in,
  input  logic             enable,
  input  logic             flush,
  input  logic             clear_err,
  input  logic             source_stall,
  output logic             source_strobe,
  output logic             busy,
  output logic [CNT_W-1:0] pending_count,
  output logic [CNT_W-1:0] issued_count,
  output logic             overflow,
  output logic             timeout_err
);
  sched_state_e     state_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] issued_q;
  logic             ovf_q, ovf_p, issue, done, abort;
  assign issue = state_q == S_IDLE && pending_count != '0 && enable && !source_stall && gap_q == '0;
  assign done  = state_q == S_WAIT_DONE && !source_stall;
  cdc_sat_counter #(.W(CNT_W)) u_pending (
    .clk    (source_clk),
    .rst    (source_reset),
    .clr_i  (flush),
    .inc_i  (event_in),
    .dec_i  (issue),
    .count_o(pending_count),
    .ovf_o  (ovf_p)
  );
`ifdef CDC_STROBE_TIMEOUT_EN
  localparam int TW = timer_w(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_q;
  logic          terr_q, stay_wait;
  assign stay_wait = (state_q == S_WAIT_BUSY && !source_stall) || (state_q == S_WAIT_DONE && source_stall);
  assign abort = stay_wait && timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign timeout_err = terr_q;
  // timer counts cycles in the current wait state and restarts on any state change
  always_ff @(posedge source_clk) begin
    if (source_reset) timer_q <= '0;
    else timer_q <= (stay_wait && !abort) ? timer_q + TW'(1) : '0;
    if (source_reset) terr_q <= 1'b0;
    else terr_q <= abort | (terr_q & ~clear_err);
  end
`else
  assign abort = 1'b0;
  assign timeout_err = 1'b0;
`endif
  assign source_strobe = state_q == S_ISSUE;
  assign busy = state_q != S_IDLE;
  assign issued_count = issued_q;
  assign overflow = ovf_q;
  // handshake FSM plus the post-completion gap, completion count and sticky overflow
  always_ff @(posedge source_clk) begin
    if (source_reset) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      issued_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= abort ? S_IDLE :
                  issue ? S_ISSUE :
                  state_q == S_ISSUE ? S_WAIT_BUSY :
                  (state_q == S_WAIT_BUSY && source_stall) ? S_WAIT_DONE :
                  done ? S_IDLE : state_q;
      gap_q    <= (done || abort) ? GAP_W'(MIN_GAP) :
                  (state_q == S_IDLE && gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
      issued_q <= issued_q + CNT_W'(done);
      ovf_q    <= ovf_p | (ovf_q & ~clear_err);
    end
  end
endmodule
